// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-fetch unit's external handshakes:
//   - instruction memory : imem_req/imem_addr (out), imem_ack/imem_rdata (in)
//   - decode stage       : ir_valid/ir/ir_pc/opcode/rd/rs/imm (out), ir_ready (in)
//   - execute redirect   : redirect/redirect_pc (in)
// Modport 'master' is the fetch unit's view; 'slave' is the memory/decode/
// execute side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [7:0]        imem_rdata;
   logic              ir_valid;
   logic              ir_ready;
   logic [7:0]        ir;
   logic [3:0]        opcode;
   logic [1:0]        rd;
   logic [1:0]        rs;
   logic [3:0]        imm;
   logic [ADDR_W-1:0] ir_pc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, ir_valid, ir, opcode, rd, rs, imm, ir_pc,
      input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, ir_valid, ir, opcode, rd, rs, imm, ir_pc,
      output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front end of the 8-bit core: fetches one instruction byte per req/ack
// transaction, holds it in the instruction register and offers it to decode
// with a valid/ready handshake. A redirect from execute (taken jmp/je)
// overrides everything except reset.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - instr_fetch_unit_if.master (memory, decode and redirect signals)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_unit_if.master  bus
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_ISSUE = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic              req_q, req_d;

   // Next-state logic. The request is a separate flop (rather than decoded
   // from state) so it is low during reset even though reset state is FETCH.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;

      unique case (state_q)
         S_FETCH: begin
            // ack without an outstanding request is ignored
            if (req_q && bus.imem_ack) begin
               ir_d       = bus.imem_rdata;
               ir_pc_d    = pc_q;
               pc_d       = pc_q + ADDR_W'(1);
               ir_valid_d = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ir_valid_q && bus.ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // Redirect wins over any same-cycle fetch or issue: a byte acked this
      // cycle is dropped and ir/ir_pc keep their previous contents.
      if (bus.redirect) begin
         pc_d       = bus.redirect_pc;
         ir_d       = ir_q;
         ir_pc_d    = ir_pc_q;
         ir_valid_d = 1'b0;
         state_d    = S_FETCH;
      end

      req_d = (state_d == S_FETCH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_pc_q    <= RESET_PC;
         ir_valid_q <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         req_q      <= req_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.ir_valid  = ir_valid_q;
   assign bus.ir        = ir_q;
   assign bus.ir_pc     = ir_pc_q;
   assign bus.opcode    = ir_q[7:4];
   assign bus.rd        = ir_q[3:2];
   assign bus.rs        = ir_q[1:0];
   assign bus.imm       = ir_q[3:0];

endmodule
